// File: rtl/sgm_line_buffer_pkg.sv
// Shared SGM parameters: default sample width, default line width and legal read-latency bounds.
package sgm_line_buffer_pkg;

    localparam int unsigned SGM_DATA_WIDTH       = 256;
    localparam int unsigned SGM_LINE_WIDTH       = 640;
    localparam int unsigned SGM_READ_LATENCY_DEF = 2;
    localparam int unsigned SGM_READ_LATENCY_MIN = 1;
    localparam int unsigned SGM_READ_LATENCY_MAX = 4;

    function automatic logic sgm_read_latency_legal(input int unsigned lat);
        return (lat >= SGM_READ_LATENCY_MIN) && (lat <= SGM_READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/sgm_sdp_ram.sv
// Inferable simple dual-port RAM: one write port, one registered read-first read port.
module sgm_sdp_ram #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned DEPTH      = 640,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] di,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= di;
        end
    end

    // Separate read process sees the pre-write contents on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sgm_line_buffer.sv
// One-line delay buffer pairing each sample with the same column of the previous line.
// Optional feature macro: SGM_LINEBUF_ZERO_FIRST_EN (zero out_prev while out_prev_valid is low).
module sgm_line_buffer
    import sgm_line_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = SGM_DATA_WIDTH,
    parameter int unsigned LINE_WIDTH   = SGM_LINE_WIDTH,
    parameter int unsigned READ_LATENCY = SGM_READ_LATENCY_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic                          in_sol,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    output logic                          out_prev_valid,
    output logic [$clog2(LINE_WIDTH)-1:0] out_col,
    output logic [DATA_WIDTH-1:0]         out_cur,
    output logic [DATA_WIDTH-1:0]         out_prev
);

    localparam int unsigned     COL_W    = $clog2(LINE_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WIDTH - 1);

    if (!sgm_read_latency_legal(READ_LATENCY)) begin : g_bad_read_latency
        $error("sgm_line_buffer: READ_LATENCY out of range");
    end
    if (LINE_WIDTH < 2) begin : g_bad_line_width
        $error("sgm_line_buffer: LINE_WIDTH must be at least 2");
    end

    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      wr_col;
    logic [COL_W-1:0]      col_next;
    logic                  first_line;
    logic                  seen_sample;
    logic                  sol_acc;
    logic                  wrap_acc;
    logic                  first_line_tag;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] prev_raw;

    logic                  vld_q   [READ_LATENCY];
    logic                  first_q [READ_LATENCY];
    logic [COL_W-1:0]      col_q   [READ_LATENCY];
    logic [DATA_WIDTH-1:0] cur_q   [READ_LATENCY];

    always_comb begin
        sol_acc  = in_valid & in_sol;
        wr_col   = sol_acc ? '0 : col;
        wrap_acc = in_valid & (wr_col == LAST_COL);
        col_next = (wr_col == LAST_COL) ? '0 : wr_col + 1'b1;
        // A start-of-line that ends a real (possibly partial) line already has a line behind it.
        first_line_tag = first_line & ~(sol_acc & seen_sample);
        wr_en          = in_valid & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col         <= '0;
            first_line  <= 1'b1;
            seen_sample <= 1'b0;
        end else if (in_valid) begin
            col         <= col_next;
            seen_sample <= 1'b1;
            if (wrap_acc || (sol_acc && seen_sample)) begin
                first_line <= 1'b0;
            end
        end
    end

    sgm_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LINE_WIDTH),
        .ADDR_WIDTH (COL_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_col),
        .di    (in_data),
        .raddr (wr_col),
        .rdata (ram_rdata)
    );

    // Stage 0 of these arrays sits alongside the RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) begin
                vld_q[k]   <= 1'b0;
                first_q[k] <= 1'b1;
                col_q[k]   <= '0;
                cur_q[k]   <= '0;
            end
        end else begin
            vld_q[0]   <= in_valid;
            first_q[0] <= first_line_tag;
            col_q[0]   <= wr_col;
            cur_q[0]   <= in_data;
            for (int unsigned k = 1; k < READ_LATENCY; k++) begin
                vld_q[k]   <= vld_q[k-1];
                first_q[k] <= first_q[k-1];
                col_q[k]   <= col_q[k-1];
                cur_q[k]   <= cur_q[k-1];
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_prev_direct
        always_comb prev_raw = ram_rdata;
    end else begin : g_prev_delay
        logic [DATA_WIDTH-1:0] prev_q [READ_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned k = 0; k < READ_LATENCY - 1; k++) begin
                    prev_q[k] <= '0;
                end
            end else begin
                prev_q[0] <= ram_rdata;
                for (int unsigned k = 1; k < READ_LATENCY - 1; k++) begin
                    prev_q[k] <= prev_q[k-1];
                end
            end
        end

        always_comb prev_raw = prev_q[READ_LATENCY-2];
    end

    always_comb begin
        out_valid      = vld_q[READ_LATENCY-1];
        out_prev_valid = vld_q[READ_LATENCY-1] & ~first_q[READ_LATENCY-1];
        out_col        = col_q[READ_LATENCY-1];
        out_cur        = cur_q[READ_LATENCY-1];
    end

`ifdef SGM_LINEBUF_ZERO_FIRST_EN
    always_comb out_prev = out_prev_valid ? prev_raw : '0;
`else
    always_comb out_prev = prev_raw;
`endif

endmodule

// File: doc/sgm_line_buffer.md
# sgm_line_buffer

Parametrised one-line delay buffer for the SGM cost-aggregation pipeline. Each accepted input sample is written to a block RAM at the current column. In the same cycle, the sample stored at that column one line earlier is read out. The block delivers the current sample and the previous-line sample together after a fixed, configurable latency. It replaces the single-port inferred RAM with a streaming, pointer-managed, dual-port buffer with valid tracking.

## Interface
- DATA_WIDTH, 256, bits per sample (packed disparity costs)
- LINE_WIDTH, 640, samples per image line = RAM depth; legal range ≥2
- READ_LATENCY, 2, cycles from input accept to output; legal range 1..4
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  sample present this cycle; no backpressure
- in_sol  in  1  start of line, qualified by in_valid; forces column 0
- in_data  in  DATA_WIDTH  current sample
- out_valid  out  1  output sample valid
- out_prev_valid  out  1  out_prev holds real previous-line data (not first line after reset)
- out_col  out  clog2(LINE_WIDTH)  column of the output sample
- out_cur  out  DATA_WIDTH  in_data delayed by READ_LATENCY
- out_prev  out  DATA_WIDTH  RAM content at out_col from the preceding line

## Operation
- col counter: advances on every in_valid.
  - Wraps LINE_WIDTH-1 → 0.
  - in_valid & in_sol: the sample uses column 0 and col becomes 1, regardless of the old value.
- first_line flag: set by reset. Cleared on the accepted sample that wraps col to 0, or on in_sol after at least one accepted sample. Never re-set except by rst.
- RAM is simple dual-port: write port at col with in_data, read port at the same address, both on the same edge.
  - Read-first: the read returns the old contents, never the data being written.
- Pipeline: valid, col, first_line and in_data are shifted in lockstep with the RAM read path.
  - The RAM read register counts as stage 1. Stages 2..READ_LATENCY are plain registers.
  - No enable: the pipeline advances every cycle. Gaps (in_valid low) propagate as out_valid low.
- out_prev_valid = out_valid & ~first_line of that sample.
- Gaps in the input do not move col. A partial line followed by in_sol discards the remainder; stale RAM entries beyond the cut stay in place.
- Reset mid-operation:
  - Clears col to 0, sets first_line, and zeroes all pipeline valid bits.
  - In-flight samples are dropped. RAM contents are not cleared.
- Simultaneous in_sol with col wrap: identical result (col 0); no conflict.

## Timing
- Reset values: out_valid 0, out_prev_valid 0, out_col 0, out_cur 0, out_prev 0.
- Sample accepted at edge t appears on the outputs after edge t+READ_LATENCY-1, i.e. valid for the whole cycle following it. Latency is fixed, independent of gaps.
- Throughput: one sample per clock sustained.
- Write at edge t is visible to a read of the same column at edge t+1 or later.
- Address width: clog2(LINE_WIDTH); for LINE_WIDTH=640, 10 bits.

## Configuration
- SGM_LINEBUF_ZERO_FIRST_EN
  - Defined: out_prev forced to all-zero whenever out_prev_valid is 0. Downstream aggregation may then consume out_prev unconditionally.
  - Undefined: out_prev is the raw RAM output (uninitialised/X in simulation during the first line). Consumers must qualify it with out_prev_valid. Saves one DATA_WIDTH-wide mux.

## Structure
- The clog2 function comes from the shared util include; no local copy.
- Legal READ_LATENCY bounds and the default SGM sample width belong in the shared SGM parameter package.
- One sub-module: sgm_sdp_ram.
  - Inferable simple dual-port RAM: write port (we, waddr, di) and registered read port (raddr, do), read-first, 1-cycle latency.
  - The line buffer wraps it and adds the counter and pipeline.

## Test plan
Bench config: DATA_WIDTH=8, LINE_WIDTH=4, READ_LATENCY=2 unless stated.
- Reset: hold rst 3 cycles with in_valid 1 → all outputs 0, no out_valid, col 0 afterwards.
- Back-to-back stream 0x10..0x17, in_sol on 0x10 → out_valid 2 cycles later.
  - out_cur 0x10..0x17, out_col 0,1,2,3,0,1,2,3.
  - out_prev_valid 0 for the first four samples, then 1 with out_prev 0x10..0x13.
- Same stream with in_valid gaps every other cycle → identical out_cur/out_prev pairing, out_valid mirrors the gaps exactly 2 cycles later.
- Short line: 0x20,0x21, then in_sol with 0x30,0x31 → out_prev 0x20,0x21 at columns 0,1. Third sample at column 2 shows stale data.
- Reset after 6 samples of the stream above, then restart 0x40.. → out_prev_valid 0 for the next line; out_prev reads prior contents (0x14.. pattern) only when the macro is undefined, else 0. In-flight samples never appear.
- Sweep READ_LATENCY 1, 3, 4 with the back-to-back stream → latency equals the parameter, data pairing unchanged.
